can_tx_scheduler: RTL and testbench
===================================

# can_tx_scheduler

Transmit-side scheduler for the CAN core. It sits between the Tx storage FIFO, a single high-priority buffer (HPB) and the bit-stream transmit engine. It chooses the next frame, with the HPB ahead of the FIFO, and pulls FIFO frames through the FIFO's registered read port. It presents one frame at a time to the engine and sequences retransmission after lost arbitration or bus errors.

## Interface
Parameters:
- DATA_W, 128, frame word width (FIFO/HPB/engine)
- CNT_W, 6, width of FIFO occupancy count
- RETRY_MAX, 16, maximum retransmissions per frame (only used with TX_RETRY_LIMIT_EN)

Ports:
- sys_clk  in  1  single system clock; all logic on rising edge
- IP2Can_reset_n  in  1  reset, asynchronous, active-low
- fifo_count  in  CNT_W  Tx FIFO occupancy; 0 = empty
- fifo_deload  out  1  one-cycle read strobe to FIFO
- fifo_data  in  DATA_W  FIFO registered read data, valid the cycle after fifo_deload
- hpb_valid  in  1  HPB holds a pending frame
- hpb_data  in  DATA_W  HPB frame, stable while hpb_valid
- hpb_clr  out  1  one-cycle pulse: HPB frame finished (ok or fail)
- tx_req  out  1  frame offered to engine
- tx_frame  out  DATA_W  frame under transmission (registered)
- tx_done  in  1  engine: frame sent and acknowledged
- tx_arb_lost  in  1  engine: arbitration lost
- tx_err  in  1  engine: bus error during frame
- tx_abort  in  1  host abort of current frame
- src_hpb  out  1  current frame came from HPB
- sched_busy  out  1  state != IDLE
- tx_ok  out  1  one-cycle success pulse
- tx_fail  out  1  one-cycle failure (abort or retry limit) pulse

## Operation
- States: IDLE, FETCH, LATCH, SEND, RETRY.
- IDLE, decision order:
  - hpb_valid=1: capture hpb_data into tx_frame, set src_hpb=1, go to SEND.
  - Else fifo_count!=0: go to FETCH.
  - Else stay in IDLE.
- FETCH: fifo_deload=1 for exactly this cycle, then LATCH.
- LATCH: capture fifo_data into tx_frame, src_hpb=0, clear retry count, then SEND.
- SEND: tx_req=1 and held until a terminating event. Per-cycle priority is tx_done > tx_abort > tx_err/tx_arb_lost.
  - tx_done: tx_ok pulse, to IDLE.
  - tx_abort: tx_fail pulse, frame dropped, to IDLE.
  - tx_err or tx_arb_lost: to RETRY.
- RETRY: tx_req=0 for one cycle, retry count +1, back to SEND with the same tx_frame.
- HPB frame ends (ok or fail): hpb_clr pulses in the same cycle as tx_ok/tx_fail.
- Arbitration is non-preemptive. An hpb_valid that rises during a FIFO frame waits for IDLE.
- Engine inputs are ignored outside SEND.
- No underflow: FETCH is entered only when fifo_count!=0.
- Exactly one fifo_deload per FIFO frame.

## Timing
- Reset values: state=IDLE; fifo_deload, hpb_clr, tx_req, src_hpb, sched_busy, tx_ok, tx_fail = 0; tx_frame=0; retry count=0.
- Reset mid-frame: returns to IDLE immediately. A frame already deloaded is lost and no tx_fail pulse is issued.
- FIFO path: IDLE decision at cycle n; fifo_deload high in n+1; capture at n+2; tx_req high from n+3.
- HPB path: IDLE decision at cycle n; tx_req high from n+1.
- After a terminating event at cycle m: IDLE at m+1, earliest next tx_req at m+2 (HPB) or m+4 (FIFO).
- Back-to-back FIFO frames never issue two fifo_deload strobes closer than 4 cycles apart.
- All outputs are registered.

## Configuration
- TX_RETRY_LIMIT_EN defined: in SEND, an error or lost arbitration with retry count == RETRY_MAX causes a tx_fail pulse and a return to IDLE instead of RETRY. Retry count width is clog2(RETRY_MAX+1).
- TX_RETRY_LIMIT_EN undefined: unlimited automatic retransmission (CAN default). The retry counter saturates at all-ones and never causes a failure.

## Structure
- Shared package can_tx_pkg: state enum (IDLE, FETCH, LATCH, SEND, RETRY), DATA_W/CNT_W defaults, RETRY_MAX default.
- One sub-module, can_tx_retry_ctr: clear/increment/saturate counter with a limit-reached output. It is compiled with the limit compare only under TX_RETRY_LIMIT_EN.

## Test plan
- FIFO single frame: fifo_count=1, fifo_data=128'hA5..A5 -> one fifo_deload pulse at n+1, tx_req at n+3 with tx_frame=A5..A5; tx_done -> tx_ok pulse, back to IDLE, no second deload.
- HPB priority: hpb_valid=1 and fifo_count=3 together in IDLE -> HPB sent first with src_hpb=1; tx_done -> hpb_clr+tx_ok; FIFO frame follows.
- Retry: inject tx_arb_lost twice, then tx_done -> tx_req low for one cycle after each loss, tx_frame unchanged, a single tx_ok.
- Retry limit (TX_RETRY_LIMIT_EN, RETRY_MAX=2): tx_err three times -> tx_fail on the third error, to IDLE. Without the macro: no tx_fail.
- Conflicts: tx_done and tx_err in the same cycle -> tx_ok only. tx_abort and tx_done in the same cycle -> tx_ok only. tx_abort alone -> tx_fail.
- Reset: drop IP2Can_reset_n during SEND -> all outputs 0 asynchronously, no pulses; after release with fifo_count=0 and hpb_valid=0, stays in IDLE.

Source files
------------

// File: rtl/can_tx_pkg.sv
// Shared definitions for the CAN transmit scheduler: state encoding and parameter defaults.
package can_tx_pkg;

  localparam int DATA_W_DEF    = 128;
  localparam int CNT_W_DEF     = 6;
  localparam int RETRY_MAX_DEF = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE  = 3'd0;
  localparam state_t ST_FETCH = 3'd1;
  localparam state_t ST_LATCH = 3'd2;
  localparam state_t ST_SEND  = 3'd3;
  localparam state_t ST_RETRY = 3'd4;

endpackage

// File: rtl/can_tx_retry_ctr.sv
// Retransmission counter: clear, increment, saturate at all-ones.
// The limit compare exists only when TX_RETRY_LIMIT_EN is defined; otherwise at_limit is tied low.
module can_tx_retry_ctr
  import can_tx_pkg::*;
#(
  parameter int LIMIT = RETRY_MAX_DEF
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic inc,
  output logic at_limit
);

  localparam int W = $clog2(LIMIT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (inc && (cnt != '1)) begin
      cnt <= cnt + 1'b1;
    end
  end

`ifdef TX_RETRY_LIMIT_EN
  assign at_limit = (cnt == W'(LIMIT));
`else
  assign at_limit = 1'b0;
`endif

endmodule

// File: rtl/can_tx_scheduler.sv
// CAN transmit scheduler: HPB ahead of FIFO, one frame at a time to the engine, retry sequencing.
// Build option: TX_RETRY_LIMIT_EN makes a frame fail once RETRY_MAX retransmissions are exhausted.
module can_tx_scheduler
  import can_tx_pkg::*;
#(
  parameter int DATA_W    = DATA_W_DEF,
  parameter int CNT_W     = CNT_W_DEF,
  parameter int RETRY_MAX = RETRY_MAX_DEF
) (
  input  logic              sys_clk,
  input  logic              IP2Can_reset_n,
  input  logic [CNT_W-1:0]  fifo_count,
  output logic              fifo_deload,
  input  logic [DATA_W-1:0] fifo_data,
  input  logic              hpb_valid,
  input  logic [DATA_W-1:0] hpb_data,
  output logic              hpb_clr,
  output logic              tx_req,
  output logic [DATA_W-1:0] tx_frame,
  input  logic              tx_done,
  input  logic              tx_arb_lost,
  input  logic              tx_err,
  input  logic              tx_abort,
  output logic              src_hpb,
  output logic              sched_busy,
  output logic              tx_ok,
  output logic              tx_fail
);

  state_t state, state_nx;
  logic   err_evt, end_ok, end_fail, retry_at_limit;

  assign err_evt  = tx_err || tx_arb_lost;
  assign end_ok   = (state == ST_SEND) && tx_done;
  assign end_fail = (state == ST_SEND) && !tx_done &&
                    (tx_abort || (err_evt && retry_at_limit));

  can_tx_retry_ctr #(.LIMIT(RETRY_MAX)) u_retry_ctr (
    .clk      (sys_clk),
    .rst_n    (IP2Can_reset_n),
    .clr      ((state == ST_IDLE) || (state == ST_LATCH)),
    .inc      (state == ST_RETRY),
    .at_limit (retry_at_limit)
  );

  // NOTE: state_nx is defaulted first so no path through the case can infer a latch.
  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: begin
        if (hpb_valid)              state_nx = ST_SEND;
        else if (fifo_count != '0)  state_nx = ST_FETCH;
      end
      ST_FETCH: state_nx = ST_LATCH;
      ST_LATCH: state_nx = ST_SEND;
      ST_SEND: begin
        if (tx_done || tx_abort)    state_nx = ST_IDLE;
        else if (err_evt)           state_nx = retry_at_limit ? ST_IDLE : ST_RETRY;
      end
      ST_RETRY: state_nx = ST_SEND;
      default:  state_nx = ST_IDLE;
    endcase
  end

  // Every output is a flop decoded from the next state, so the engine and FIFO see clean edges.
  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge sys_clk or negedge IP2Can_reset_n) begin
    if (!IP2Can_reset_n) begin
      state       <= ST_IDLE;
      fifo_deload <= 1'b0;
      hpb_clr     <= 1'b0;
      tx_req      <= 1'b0;
      tx_frame    <= '0;
      src_hpb     <= 1'b0;
      sched_busy  <= 1'b0;
      tx_ok       <= 1'b0;
      tx_fail     <= 1'b0;
    end else begin
      state       <= state_nx;
      fifo_deload <= (state_nx == ST_FETCH);
      tx_req      <= (state_nx == ST_SEND);
      sched_busy  <= (state_nx != ST_IDLE);
      tx_ok       <= end_ok;
      tx_fail     <= end_fail;
      hpb_clr     <= (end_ok || end_fail) && src_hpb;
      if ((state == ST_IDLE) && hpb_valid) begin
        tx_frame <= hpb_data;
        src_hpb  <= 1'b1;
      end else if (state == ST_LATCH) begin
        tx_frame <= fifo_data;
        src_hpb  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_can_tx_scheduler.sv
// Self-checking bench for can_tx_scheduler: directed scenarios plus randomized frames against a frame-level model.
`timescale 1ns/1ps
module tb_can_tx_scheduler;

  localparam int DATA_W    = 128;
  localparam int CNT_W     = 6;
  localparam int RETRY_MAX = 2;
`ifdef TX_RETRY_LIMIT_EN
  localparam bit LIMIT_EN = 1'b1;
`else
  localparam bit LIMIT_EN = 1'b0;
`endif

  logic              sys_clk = 1'b0;
  logic              IP2Can_reset_n;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_deload;
  logic [DATA_W-1:0] fifo_data;
  logic              hpb_valid;
  logic [DATA_W-1:0] hpb_data;
  logic              hpb_clr, tx_req, src_hpb, sched_busy, tx_ok, tx_fail;
  logic [DATA_W-1:0] tx_frame;
  logic              tx_done, tx_arb_lost, tx_err, tx_abort;

  can_tx_scheduler #(.DATA_W(DATA_W), .CNT_W(CNT_W), .RETRY_MAX(RETRY_MAX)) dut (
    .sys_clk(sys_clk), .IP2Can_reset_n(IP2Can_reset_n),
    .fifo_count(fifo_count), .fifo_deload(fifo_deload), .fifo_data(fifo_data),
    .hpb_valid(hpb_valid), .hpb_data(hpb_data), .hpb_clr(hpb_clr),
    .tx_req(tx_req), .tx_frame(tx_frame),
    .tx_done(tx_done), .tx_arb_lost(tx_arb_lost), .tx_err(tx_err), .tx_abort(tx_abort),
    .src_hpb(src_hpb), .sched_busy(sched_busy), .tx_ok(tx_ok), .tx_fail(tx_fail)
  );

  always #5 sys_clk = ~sys_clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog");
  end

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int last_deload = -100;
  int deload_cnt  = 0;

  // FIFO storage as the bench sees it (fifo_q) and the order frames must be presented in (ref_q).
  logic [DATA_W-1:0] fifo_q[$];
  logic [DATA_W-1:0] ref_q[$];
  logic [DATA_W-1:0] pend;
  bit                pend_valid = 1'b0;

  function automatic logic [DATA_W-1:0] rand_frame();
    logic [DATA_W-1:0] f;
    for (int i = 0; i < DATA_W / 32; i++) f[i*32 +: 32] = $urandom();
    return f;
  endfunction

  // One cycle: advance to the falling edge, then play FIFO and HPB behaviour for the next rising edge.
  task automatic tick();
    @(negedge sys_clk);
    cyc++;
    if (pend_valid) begin
      fifo_data  = pend;
      pend_valid = 1'b0;
    end else begin
      fifo_data = rand_frame();
    end
    if (fifo_deload) begin
      total++;
      if ((cyc - last_deload) < 4 || fifo_q.size() == 0) begin
        bad++;
        $display("FAIL deload_rule: gap=%0d fifo_entries=%0d required gap>=4 and entries>0",
                 cyc - last_deload, fifo_q.size());
      end
      last_deload = cyc;
      deload_cnt++;
      if (fifo_q.size() != 0) begin
        pend       = fifo_q.pop_front();
        pend_valid = 1'b1;
      end
    end
    fifo_count = CNT_W'(fifo_q.size());
    if (hpb_clr) hpb_valid = 1'b0;
  endtask

  task automatic engine_quiet();
    tx_done = 1'b0; tx_arb_lost = 1'b0; tx_err = 1'b0; tx_abort = 1'b0;
  endtask

  task automatic push_fifo(input logic [DATA_W-1:0] f);
    fifo_q.push_back(f);
    ref_q.push_back(f);
    fifo_count = CNT_W'(fifo_q.size());
  endtask

  task automatic wait_req(output int lat);
    lat = -1;
    for (int i = 1; i <= 8; i++) begin
      tick();
      if (tx_req) begin
        lat = i;
        break;
      end
    end
  endtask

  task automatic test_reset();
    IP2Can_reset_n = 1'b0;
    fifo_count = '0; fifo_data = '0; hpb_valid = 1'b0; hpb_data = '0;
    engine_quiet();
    tick(); tick();
    total++;
    if ({fifo_deload, hpb_clr, tx_req, src_hpb, sched_busy, tx_ok, tx_fail} !== 7'b0) begin
      bad++;
      $display("FAIL reset_flags: got=%b want=0000000",
               {fifo_deload, hpb_clr, tx_req, src_hpb, sched_busy, tx_ok, tx_fail});
    end
    total++;
    if (tx_frame !== '0) begin bad++; $display("FAIL reset_frame: got=%h want=0", tx_frame); end
    IP2Can_reset_n = 1'b1;
    repeat (3) tick();
    total++;
    if (sched_busy !== 1'b0 || tx_req !== 1'b0 || deload_cnt != 0) begin
      bad++;
      $display("FAIL idle_after_reset: busy=%b req=%b deloads=%0d want 0/0/0", sched_busy, tx_req, deload_cnt);
    end
  endtask

  task automatic test_fifo_single();
    logic [DATA_W-1:0] a5;
    logic [DATA_W-1:0] want;
    int d0;
    a5 = {16{8'hA5}};
    d0 = deload_cnt;
    push_fifo(a5);
    tick();
    total++;
    if (fifo_deload !== 1'b1) begin bad++; $display("FAIL single_deload_n1: got=%b want=1", fifo_deload); end
    tick();
    total++;
    if (fifo_deload !== 1'b0 || tx_req !== 1'b0 || sched_busy !== 1'b1) begin
      bad++;
      $display("FAIL single_latch_n2: deload=%b req=%b busy=%b want 0/0/1", fifo_deload, tx_req, sched_busy);
    end
    tick();
    want = ref_q.pop_front();
    total++;
    if (tx_req !== 1'b1 || tx_frame !== want || src_hpb !== 1'b0) begin
      bad++;
      $display("FAIL single_req_n3: req=%b src=%b frame=%h want 1/0/%h", tx_req, src_hpb, tx_frame, want);
    end
    tx_done = 1'b1;
    tick();
    engine_quiet();
    total++;
    if (tx_ok !== 1'b1 || tx_req !== 1'b0 || sched_busy !== 1'b0 || hpb_clr !== 1'b0) begin
      bad++;
      $display("FAIL single_done: ok=%b req=%b busy=%b clr=%b want 1/0/0/0", tx_ok, tx_req, sched_busy, hpb_clr);
    end
    repeat (4) tick();
    total++;
    if (deload_cnt != d0 + 1 || tx_ok !== 1'b0) begin
      bad++;
      $display("FAIL single_no_extra: deloads=%0d ok=%b want %0d/0", deload_cnt - d0, tx_ok, 1);
    end
  endtask

  task automatic test_hpb_priority();
    logic [DATA_W-1:0] h;
    logic [DATA_W-1:0] want;
    int lat;
    h = rand_frame();
    for (int i = 0; i < 3; i++) push_fifo(rand_frame());
    hpb_valid = 1'b1;
    hpb_data  = h;
    wait_req(lat);
    total++;
    if (lat != 1 || src_hpb !== 1'b1 || tx_frame !== h) begin
      bad++;
      $display("FAIL hpb_first: lat=%0d src=%b frame=%h want 1/1/%h", lat, src_hpb, tx_frame, h);
    end
    tx_done = 1'b1;
    tick();
    engine_quiet();
    total++;
    if (hpb_clr !== 1'b1 || tx_ok !== 1'b1 || tx_fail !== 1'b0) begin
      bad++;
      $display("FAIL hpb_done: clr=%b ok=%b fail=%b want 1/1/0", hpb_clr, tx_ok, tx_fail);
    end
    wait_req(lat);
    want = ref_q.pop_front();
    total++;
    if (lat != 3 || src_hpb !== 1'b0 || tx_frame !== want) begin
      bad++;
      $display("FAIL fifo_follows: lat=%0d src=%b frame=%h want 3/0/%h", lat, src_hpb, tx_frame, want);
    end
    tx_done = 1'b1;
    tick();
    engine_quiet();
    total++;
    if (tx_ok !== 1'b1 || hpb_clr !== 1'b0) begin
      bad++;
      $display("FAIL fifo_follows_done: ok=%b clr=%b want 1/0", tx_ok, hpb_clr);
    end
  endtask

  // Two FIFO frames remain; an HPB request arrives mid-frame and must wait its turn.
  task automatic test_back_to_back();
    logic [DATA_W-1:0] h;
    logic [DATA_W-1:0] want;
    int lat;
    h = rand_frame();
    tick();
    hpb_valid = 1'b1;
    hpb_data  = h;
    tick(); tick();
    want = ref_q.pop_front();
    total++;
    if (tx_req !== 1'b1 || src_hpb !== 1'b0 || tx_frame !== want) begin
      bad++;
      $display("FAIL no_preempt: req=%b src=%b frame=%h want 1/0/%h", tx_req, src_hpb, tx_frame, want);
    end
    tx_done = 1'b1;
    tick();
    engine_quiet();
    wait_req(lat);
    total++;
    if (lat != 1 || src_hpb !== 1'b1 || tx_frame !== h) begin
      bad++;
      $display("FAIL hpb_after_fifo: lat=%0d src=%b frame=%h want 1/1/%h", lat, src_hpb, tx_frame, h);
    end
    tx_done = 1'b1;
    tick();
    engine_quiet();
    wait_req(lat);
    want = ref_q.pop_front();
    total++;
    if (lat != 3 || tx_frame !== want) begin
      bad++;
      $display("FAIL last_fifo: lat=%0d frame=%h want 3/%h", lat, tx_frame, want);
    end
    tx_done = 1'b1;
    tick();
    engine_quiet();
    total++;
    if (tx_ok !== 1'b1 || fifo_q.size() != 0) begin
      bad++;
      $display("FAIL drain: ok=%b left=%0d want 1/0", tx_ok, fifo_q.size());
    end
  endtask

  task automatic test_retry();
    logic [DATA_W-1:0] want;
    int lat;
    push_fifo(rand_frame());
    wait_req(lat);
    want = ref_q.pop_front();
    total++;
    if (lat != 3 || tx_frame !== want) begin
      bad++;
      $display("FAIL retry_start: lat=%0d frame=%h want 3/%h", lat, tx_frame, want);
    end
    for (int k = 0; k < 2; k++) begin
      tx_arb_lost = 1'b1;
      tick();
      engine_quiet();
      total++;
      if (tx_req !== 1'b0 || sched_busy !== 1'b1 || tx_fail !== 1'b0) begin
        bad++;
        $display("FAIL retry_gap%0d: req=%b busy=%b fail=%b want 0/1/0", k, tx_req, sched_busy, tx_fail);
      end
      tick();
      total++;
      if (tx_req !== 1'b1 || tx_frame !== want) begin
        bad++;
        $display("FAIL retry_resend%0d: req=%b frame=%h want 1/%h", k, tx_req, tx_frame, want);
      end
    end
    tx_done = 1'b1;
    tick();
    engine_quiet();
    total++;
    if (tx_ok !== 1'b1 || tx_fail !== 1'b0) begin
      bad++;
      $display("FAIL retry_done: ok=%b fail=%b want 1/0", tx_ok, tx_fail);
    end
    tick();
    total++;
    if (tx_ok !== 1'b0) begin bad++; $display("FAIL retry_single_ok: ok=%b want 0", tx_ok); end
  endtask

  task automatic test_retry_limit();
    logic [DATA_W-1:0] h;
    bit exp_fail;
    bit sending;
    int lat;
    h = rand_frame();
    hpb_valid = 1'b1;
    hpb_data  = h;
    wait_req(lat);
    sending = 1'b1;
    for (int e = 1; e <= RETRY_MAX + 1; e++) begin
      tx_err = 1'b1;
      tick();
      engine_quiet();
      exp_fail = LIMIT_EN && (e > RETRY_MAX);
      total++;
      if (tx_fail !== exp_fail || hpb_clr !== exp_fail || tx_req !== 1'b0 || sched_busy !== !exp_fail) begin
        bad++;
        $display("FAIL limit_err%0d: fail=%b clr=%b req=%b busy=%b want %b/%b/0/%b",
                 e, tx_fail, hpb_clr, tx_req, sched_busy, exp_fail, exp_fail, !exp_fail);
      end
      if (exp_fail) begin
        sending = 1'b0;
        break;
      end
      tick();
    end
    if (sending) begin
      tx_done = 1'b1;
      tick();
      engine_quiet();
      total++;
      if (tx_ok !== 1'b1 || tx_fail !== 1'b0 || hpb_clr !== 1'b1) begin
        bad++;
        $display("FAIL limit_unlimited: ok=%b fail=%b clr=%b want 1/0/1", tx_ok, tx_fail, hpb_clr);
      end
    end
  endtask

  task automatic test_conflicts();
    // columns: done, abort, err -> expected ok, fail
    bit [4:0] tbl[4] = '{5'b100_10, 5'b110_10, 5'b010_01, 5'b011_01};
    int lat;
    for (int i = 0; i < 4; i++) begin
      hpb_valid = 1'b1;
      hpb_data  = rand_frame();
      wait_req(lat);
      tx_done  = tbl[i][4];
      tx_abort = tbl[i][3];
      tx_err   = tbl[i][2];
      tick();
      engine_quiet();
      total++;
      if (tx_ok !== tbl[i][1] || tx_fail !== tbl[i][0] || hpb_clr !== 1'b1 || tx_req !== 1'b0) begin
        bad++;
        $display("FAIL conflict%0d: ok=%b fail=%b clr=%b req=%b want %b/%b/1/0",
                 i, tx_ok, tx_fail, hpb_clr, tx_req, tbl[i][1], tbl[i][0]);
      end
    end
  endtask

  task automatic test_random();
    logic [DATA_W-1:0] f;
    logic [DATA_W-1:0] want;
    bit is_hpb, end_abort, exp_fail, ended;
    int lat, n_err, fail_at;
    for (int n = 0; n < 40; n++) begin
      is_hpb = 1'($urandom_range(0, 1));
      f = rand_frame();
      if (is_hpb) begin
        hpb_valid = 1'b1;
        hpb_data  = f;
      end else begin
        push_fifo(f);
      end
      wait_req(lat);
      want = is_hpb ? f : ref_q.pop_front();
      total++;
      if (lat != (is_hpb ? 1 : 3) || tx_frame !== want || src_hpb !== is_hpb) begin
        bad++;
        $display("FAIL rnd%0d_start: lat=%0d src=%b frame=%h want %0d/%b/%h",
                 n, lat, src_hpb, tx_frame, is_hpb ? 1 : 3, is_hpb, want);
      end
      if (lat < 0) break;
      n_err     = $urandom_range(0, 4);
      end_abort = ($urandom_range(0, 4) == 0);
      fail_at   = (LIMIT_EN && n_err > RETRY_MAX) ? RETRY_MAX + 1 : 0;
      ended     = 1'b0;
      for (int e = 1; e <= n_err; e++) begin
        repeat ($urandom_range(0, 2)) tick();
        if ($urandom_range(0, 1) != 0) tx_err = 1'b1; else tx_arb_lost = 1'b1;
        tick();
        engine_quiet();
        exp_fail = (e == fail_at);
        total++;
        if (tx_fail !== exp_fail || tx_req !== 1'b0 || tx_ok !== 1'b0) begin
          bad++;
          $display("FAIL rnd%0d_err%0d: fail=%b req=%b ok=%b want %b/0/0", n, e, tx_fail, tx_req, tx_ok, exp_fail);
        end
        if (exp_fail) begin
          ended = 1'b1;
          break;
        end
        tx_done  = 1'($urandom_range(0, 1));
        tx_abort = 1'($urandom_range(0, 1));
        tick();
        engine_quiet();
        total++;
        if (tx_req !== 1'b1 || tx_frame !== want || tx_ok !== 1'b0 || tx_fail !== 1'b0) begin
          bad++;
          $display("FAIL rnd%0d_resend%0d: req=%b ok=%b fail=%b frame=%h want 1/0/0/%h",
                   n, e, tx_req, tx_ok, tx_fail, tx_frame, want);
        end
      end
      if (!ended) begin
        repeat ($urandom_range(0, 2)) tick();
        if (end_abort) begin
          tx_abort = 1'b1;
          tx_err   = 1'($urandom_range(0, 1));
        end else begin
          tx_done  = 1'b1;
          tx_abort = 1'($urandom_range(0, 1));
          tx_err   = 1'($urandom_range(0, 1));
        end
        tick();
        engine_quiet();
        total++;
        if (tx_ok !== !end_abort || tx_fail !== end_abort || sched_busy !== 1'b0) begin
          bad++;
          $display("FAIL rnd%0d_end: ok=%b fail=%b busy=%b want %b/%b/0",
                   n, tx_ok, tx_fail, sched_busy, !end_abort, end_abort);
        end
      end
      total++;
      if (hpb_clr !== is_hpb) begin
        bad++;
        $display("FAIL rnd%0d_clr: clr=%b want %b", n, hpb_clr, is_hpb);
      end
      tick();
      total++;
      if (tx_ok !== 1'b0 || tx_fail !== 1'b0 || hpb_clr !== 1'b0) begin
        bad++;
        $display("FAIL rnd%0d_pulse_width: ok=%b fail=%b clr=%b want 0/0/0", n, tx_ok, tx_fail, hpb_clr);
      end
    end
  endtask

  task automatic test_reset_mid_frame();
    int lat, d0;
    push_fifo(rand_frame());
    wait_req(lat);
    void'(ref_q.pop_front());
    IP2Can_reset_n = 1'b0;
    #1;
    total++;
    if ({fifo_deload, hpb_clr, tx_req, src_hpb, sched_busy, tx_ok, tx_fail} !== 7'b0 || tx_frame !== '0) begin
      bad++;
      $display("FAIL async_reset: flags=%b frame=%h want 0000000/0",
               {fifo_deload, hpb_clr, tx_req, src_hpb, sched_busy, tx_ok, tx_fail}, tx_frame);
    end
    tick();
    IP2Can_reset_n = 1'b1;
    d0 = deload_cnt;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (sched_busy !== 1'b0 || tx_req !== 1'b0 || tx_fail !== 1'b0 || tx_ok !== 1'b0) begin
        bad++;
        $display("FAIL post_reset_idle%0d: busy=%b req=%b fail=%b ok=%b want 0/0/0/0",
                 i, sched_busy, tx_req, tx_fail, tx_ok);
      end
    end
    total++;
    if (deload_cnt != d0) begin bad++; $display("FAIL post_reset_deload: got=%0d want 0", deload_cnt - d0); end
  endtask

  initial begin
    test_reset();
    test_fifo_single();
    test_hpb_priority();
    test_back_to_back();
    test_retry();
    test_retry_limit();
    test_conflicts();
    test_random();
    test_reset_mid_frame();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
